// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day clock: BCD digit, HH:MM:SS record,
// segment patterns and a two-digit BCD increment helper.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    // Packed so that digit n (s1 = 0 .. h10 = 5) sits at bits [4n+3:4n].
    typedef struct packed {
        bcd_t h10;
        bcd_t h1;
        bcd_t m10;
        bcd_t m1;
        bcd_t s10;
        bcd_t s1;
    } time_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam time_t      TIME_ZERO = '0;

    // Increment a two-digit BCD field, wrapping to 00 after {max_tens, max_ones}.
    function automatic logic [7:0] bcd2_inc(input bcd_t tens, input bcd_t ones,
                                            input bcd_t max_tens, input bcd_t max_ones);
        logic [7:0] r;
        if (tens == max_tens && ones == max_ones) begin
            r = 8'h00;
        end else if (ones == 4'd9) begin
            r = {tens + 4'd1, 4'd0};
        end else begin
            r = {tens, ones + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
module seg7_decode
    import clock_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_ZERO;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/time_keeper.sv
// BCD HH:MM:SS time-of-day counter with hours/minutes set mode and registered 7-segment outputs.
// Define DIGIT_BLINK_EN to blink the field being set at BLINK_HZ.
module time_keeper
    import clock_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BLINK_HZ = 2
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       set_hours,
    input  logic       set_minutes,
    input  logic       inc,
    output logic       tick_1hz,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam int            PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);

    if (CLK_HZ < 2 || BLINK_HZ < 1) begin : g_cfg_check
        $error("time_keeper: CLK_HZ must be >= 2 and BLINK_HZ >= 1");
    end

    logic [PW-1:0] presc_reg, presc_next;
    time_t         time_reg, time_next;
    logic          min_mode_prev_reg;
    logic          tick_next;
    logic          set_mode, hours_mode, minutes_mode;
    logic          sec_wrap, min_wrap;
    logic          blank_hours, blank_minutes;
    logic [5:0]    field_blank;
    logic [41:0]   hex_bus;

    // Hours set wins when both levels are high.
    assign set_mode     = set_hours | set_minutes;
    assign hours_mode   = set_hours;
    assign minutes_mode = set_minutes & ~set_hours;
    assign sec_wrap     = (time_reg.s10 == 4'd5) && (time_reg.s1 == 4'd9);
    assign min_wrap     = (time_reg.m10 == 4'd5) && (time_reg.m1 == 4'd9);

    always_comb begin
        presc_next = presc_reg;
        time_next  = time_reg;
        tick_next  = 1'b0;
        if (set_mode) begin
            presc_next = '0;
            if (hours_mode) begin
                if (inc) begin
                    {time_next.h10, time_next.h1} = bcd2_inc(time_reg.h10, time_reg.h1, 4'd2, 4'd3);
                end
            end else begin
                if (!min_mode_prev_reg) begin
                    time_next.s10 = 4'd0;
                    time_next.s1  = 4'd0;
                end
                if (inc) begin
                    {time_next.m10, time_next.m1} = bcd2_inc(time_reg.m10, time_reg.m1, 4'd5, 4'd9);
                end
            end
        end else if (presc_reg == PRESC_TC) begin
            presc_next = '0;
            tick_next  = 1'b1;
            {time_next.s10, time_next.s1} = bcd2_inc(time_reg.s10, time_reg.s1, 4'd5, 4'd9);
            if (sec_wrap) begin
                {time_next.m10, time_next.m1} = bcd2_inc(time_reg.m10, time_reg.m1, 4'd5, 4'd9);
            end
            if (sec_wrap && min_wrap) begin
                {time_next.h10, time_next.h1} = bcd2_inc(time_reg.h10, time_reg.h1, 4'd2, 4'd3);
            end
        end else begin
            presc_next = presc_reg + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            presc_reg         <= '0;
            time_reg          <= TIME_ZERO;
            min_mode_prev_reg <= 1'b0;
        end else begin
            presc_reg         <= presc_next;
            time_reg          <= time_next;
            min_mode_prev_reg <= minutes_mode;
        end
    end

    assign tick_1hz = tick_next;

`ifdef DIGIT_BLINK_EN
    localparam int            HALF     = CLK_HZ / (2 * BLINK_HZ);
    localparam int            BW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BW-1:0] BLINK_TC = BW'(HALF - 1);

    if (CLK_HZ < 2 * BLINK_HZ) begin : g_blink_cfg_check
        $error("time_keeper: CLK_HZ must be >= 2*BLINK_HZ with DIGIT_BLINK_EN");
    end

    logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
    logic          blink_off_reg, blink_off_next;

    // Held in the lit phase outside set mode, so entering set mode always starts lit.
    always_comb begin
        blink_cnt_next = blink_cnt_reg;
        blink_off_next = blink_off_reg;
        if (!set_mode || inc) begin
            blink_cnt_next = '0;
            blink_off_next = 1'b0;
        end else if (blink_cnt_reg == BLINK_TC) begin
            blink_cnt_next = '0;
            blink_off_next = ~blink_off_reg;
        end else begin
            blink_cnt_next = blink_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            blink_cnt_reg <= '0;
            blink_off_reg <= 1'b0;
        end else begin
            blink_cnt_reg <= blink_cnt_next;
            blink_off_reg <= blink_off_next;
        end
    end

    assign blank_hours   = hours_mode & blink_off_reg;
    assign blank_minutes = minutes_mode & blink_off_reg;
`else
    assign blank_hours   = 1'b0;
    assign blank_minutes = 1'b0;
`endif

    assign field_blank = {blank_hours, blank_hours, blank_minutes, blank_minutes, 2'b00};

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            logic [6:0] seg_raw;
            logic [6:0] hex_reg;

            seg7_decode u_dec (
                .digit (time_reg[gi*4 +: 4]),
                .seg   (seg_raw)
            );

            always_ff @(posedge CLOCK_50 or posedge rst) begin
                if (rst) begin
                    hex_reg <= SEG_ZERO;
                end else begin
                    hex_reg <= field_blank[gi] ? SEG_BLANK : seg_raw;
                end
            end

            assign hex_bus[gi*7 +: 7] = hex_reg;
        end
    endgenerate

    assign HEX0 = hex_bus[6:0];
    assign HEX1 = hex_bus[13:7];
    assign HEX2 = hex_bus[20:14];
    assign HEX3 = hex_bus[27:21];
    assign HEX4 = hex_bus[34:28];
    assign HEX5 = hex_bus[41:35];

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper: vector table, corner-case sequences and random
// stimulus against a seconds-of-day reference model.
module tb_time_keeper;
    import clock_pkg::*;

    localparam int CLK_HZ   = 10;
    localparam int BLINK_HZ = 1;
    localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);

    logic       CLOCK_50 = 1'b0;
    logic       rst = 1'b1;
    logic       set_hours = 1'b0;
    logic       set_minutes = 1'b0;
    logic       inc = 1'b0;
    logic       tick_1hz;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    time_keeper #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) dut (
        .CLOCK_50    (CLOCK_50),
        .rst         (rst),
        .set_hours   (set_hours),
        .set_minutes (set_minutes),
        .inc         (inc),
        .tick_1hz    (tick_1hz),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX2        (HEX2),
        .HEX3        (HEX3),
        .HEX4        (HEX4),
        .HEX5        (HEX5)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model: time as seconds of day, prescaler count, cycles spent in set mode.
    int          m_t;
    int          m_cnt;
    int          m_k;
    bit          m_minprev;
    logic [41:0] m_hex;

    logic        tick_seen;
    logic [41:0] hex_seen;

    typedef struct {
        bit sh;
        bit sm;
        int n_inc;
        int n_run;
        int hh;
        int mm;
        int ss;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] disp(input int t, input bit bh, input bit bm);
        int h;
        int m;
        int s;
        logic [41:0] r;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        r = {seg_of(h / 10), seg_of(h % 10), seg_of(m / 10), seg_of(m % 10),
             seg_of(s / 10), seg_of(s % 10)};
        if (bh) r[41:28] = {SEG_BLANK, SEG_BLANK};
        if (bm) r[27:14] = {SEG_BLANK, SEG_BLANK};
        return r;
    endfunction

    function automatic logic [41:0] dut_hex();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    task automatic chk(input string name, input logic [41:0] got, input logic [41:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t       = 0;
        m_cnt     = 0;
        m_k       = 0;
        m_minprev = 1'b0;
        m_hex     = {6{SEG_ZERO}};
    endtask

    task automatic model_clock(input bit sh, input bit sm, input bit iv);
        int h;
        int mi;
        int s;
        bit bh;
        bit bm;
        bh = 1'b0;
        bm = 1'b0;
`ifdef DIGIT_BLINK_EN
        if (((m_k / HALF) % 2) == 1) begin
            bh = sh;
            bm = sm && !sh;
        end
`endif
        m_hex = disp(m_t, bh, bm);
        if (!sh && !sm) begin
            if (m_cnt == CLK_HZ - 1) begin
                m_cnt = 0;
                m_t   = (m_t + 1) % 86400;
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0;
            h  = m_t / 3600;
            mi = (m_t / 60) % 60;
            s  = m_t % 60;
            if (sh) begin
                if (iv) h = (h + 1) % 24;
            end else begin
                if (!m_minprev) s = 0;
                if (iv) mi = (mi + 1) % 60;
            end
            m_t = h * 3600 + mi * 60 + s;
        end
        m_k       = ((!sh && !sm) || iv) ? 0 : m_k + 1;
        m_minprev = sm && !sh;
    endtask

    // One clock cycle: drive at the falling edge, compare 1 time unit later.
    task automatic step(input bit sh, input bit sm, input bit iv);
        set_hours   = sh;
        set_minutes = sm;
        inc         = iv;
        #1;
        tick_seen = tick_1hz;
        hex_seen  = dut_hex();
        chk("tick", 42'(tick_1hz), 42'(!sh && !sm && m_cnt == CLK_HZ - 1));
        chk("hex", hex_seen, m_hex);
        @(posedge CLOCK_50);
        model_clock(sh, sm, iv);
        @(negedge CLOCK_50);
    endtask

    task automatic pulses(input bit sh, input bit sm, input int n);
        if (n == 0) step(sh, sm, 1'b0);
        for (int i = 0; i < n; i++) begin
            step(sh, sm, 1'b1);
            step(sh, sm, 1'b0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_hex", dut_hex(), {6{SEG_ZERO}});
        chk("rst_tick", 42'(tick_1hz), 42'(0));
        model_reset();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        rst = 1'b0;
    endtask

    initial begin
        int got;
        int total;
        logic [6:0] exp5;

        vecs[0] = '{0, 0, 0,  10,  0,  0,  1};
        vecs[1] = '{1, 0, 25, 0,   1,  0,  1};
        vecs[2] = '{0, 1, 59, 0,   1, 59,  0};
        vecs[3] = '{1, 0, 22, 0,  23, 59,  0};
        vecs[4] = '{0, 0, 0,  590, 23, 59, 59};
        vecs[5] = '{0, 0, 0,  10,  0,  0,  0};
        vecs[6] = '{1, 1, 3,  0,   3,  0,  0};
        vecs[7] = '{0, 1, 61, 0,   3,  1,  0};
        vecs[8] = '{0, 0, 0,  30,  3,  1,  3};

        model_reset();
        @(negedge CLOCK_50);
        do_reset();

        // First tick lands on run cycle CLK_HZ; display follows one cycle later.
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk($sformatf("first_tick_c%0d", i), 42'(tick_seen), 42'(i == 10));
        end
        step(1'b0, 1'b0, 1'b0);
        chk("hex0_one", 42'(HEX0), 42'(7'b1111001));
        $display("seq first_tick: 10 run cycles, HEX0=%b", HEX0);

        do_reset();
        for (int v = 0; v < 9; v++) begin
            if (vecs[v].sh || vecs[v].sm) pulses(vecs[v].sh, vecs[v].sm, vecs[v].n_inc);
            run(vecs[v].n_run);
            step(1'b0, 1'b0, 1'b0);
            chk($sformatf("vec%0d", v), dut_hex(),
                disp(vecs[v].hh * 3600 + vecs[v].mm * 60 + vecs[v].ss, 1'b0, 1'b0));
            $display("vec %0d: sh=%0b sm=%0b inc=%0d run=%0d -> expect %02d:%02d:%02d",
                     v, vecs[v].sh, vecs[v].sm, vecs[v].n_inc, vecs[v].n_run,
                     vecs[v].hh, vecs[v].mm, vecs[v].ss);
        end

        // 00:12:34, minutes set clears seconds, 48 incs wrap minutes without touching hours.
        do_reset();
        pulses(1'b0, 1'b1, 12);
        run(340);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("min_entry_sec0", dut_hex(), disp(12 * 60, 1'b0, 1'b0));
        pulses(1'b0, 1'b1, 48);
        chk("min_wrap", dut_hex(), disp(0, 1'b0, 1'b0));
        $display("seq minutes_set: 00:12:34 -> 48 incs -> HEX=%h", dut_hex());

        // Both levels high: hours only; then first tick CLK_HZ cycles after release.
        do_reset();
        pulses(1'b1, 1'b1, 3);
        got = 0;
        for (int c = 1; c <= 20 && got == 0; c++) begin
            step(1'b0, 1'b0, 1'b0);
            if (c == 1) chk("both_set_hours", dut_hex(), disp(3 * 3600, 1'b0, 1'b0));
            if (tick_seen) got = c;
        end
        chk("tick_after_drop", 42'(got), 42'(10));
        $display("seq both_set: tick in cycle %0d after release", got);

        // inc on the cycle the set level drops is ignored.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("inc_on_drop", dut_hex(), disp(3 * 3600 + 1, 1'b0, 1'b0));
        $display("seq inc_on_drop: HEX=%h", dut_hex());

        // Reset in the middle of hours set.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        set_hours = 1'b1;
        do_reset();
        $display("seq reset_mid_set: HEX=%h", dut_hex());

        // Hours field held in set mode for 20 cycles.
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
`ifdef DIGIT_BLINK_EN
            exp5 = (i >= 2 && ((i - 2) / HALF) % 2 == 1) ? SEG_BLANK : SEG_ZERO;
`else
            exp5 = SEG_ZERO;
`endif
            chk($sformatf("hours_field_c%0d", i), 42'(hex_seen[41:35]), 42'(exp5));
            chk($sformatf("other_fields_c%0d", i), 42'(hex_seen[27:0]), 42'({4{SEG_ZERO}}));
        end
        $display("seq hours_hold: 20 cycles in hours set");

        // Random bursts of mixed modes against the model.
        do_reset();
        total = 0;
        while (total < 3000) begin
            int r;
            int len;
            bit sh;
            bit sm;
            r   = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 30));
            sh  = (r == 6 || r == 7 || r == 9);
            sm  = (r == 8 || r == 9);
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
            end
            for (int i = 0; i < len; i++) begin
                step(sh, sm, $urandom_range(0, 2) == 0);
            end
            total += len;
        end
        $display("seq random: %0d cycles, model time %0d s", total, m_t);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
